// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg : shared types/constants for the data-memory responder   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpu_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    localparam int DMEM_MAX_WAIT = 15;

    // WAIT counter reload value; the WAIT state counts down to zero inclusive.
    function automatic logic [3:0] dmem_wait_load(input int wait_cycles);
        return (wait_cycles > 0) ? 4'(wait_cycles - 1) : 4'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_ram : word array, per-byte synchronous write, async read    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_resp : single-outstanding data-memory responder with waits  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dmem_resp
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int         c_aw        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_wait_load = dmem_wait_load(WAIT_CYCLES);

    generate
        if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("dmem_resp: DEPTH_WORDS must be a power of two and at least 4");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > DMEM_MAX_WAIT) begin : g_bad_wait
            $error("dmem_resp: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    dmem_state_t r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    logic            w_accept, w_resp, w_err;
    logic [31:0]     w_off, w_ram_rdata;
    logic [c_aw-1:0] w_idx;
    logic [3:0]      w_ram_we;

    assign gnt_o    = (r_state != DMEM_WAIT);
    assign w_accept = req_i && gnt_o;

    // Offset wraps for addresses below the window, so one compare covers both sides.
    assign w_off = r_addr - BASE_ADDR;
    assign w_err = (r_addr[1:0] != 2'b00) || ((w_off >> 2) >= 32'(DEPTH_WORDS));
    assign w_idx = w_off[c_aw+1:2];

    // A reset edge landing on the response cycle must suppress both the strobe and the write.
    assign w_resp   = (r_state == DMEM_RESP) && rst_n;
    assign rvalid_o = w_resp;
    assign err_o    = w_resp && w_err;
    assign rdata_o  = (w_resp && !r_we && !w_err) ? w_ram_rdata : 32'h0;
    assign w_ram_we = (w_resp && r_we && !w_err) ? r_be : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            DMEM_IDLE, DMEM_RESP: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
                    w_cnt_nxt   = c_wait_load;
                end else begin
                    w_state_nxt = DMEM_IDLE;
                end
            end
            DMEM_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = DMEM_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DMEM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
        end
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_aw)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_idx),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of word 0 of the responder window.
REQ-002 Parameter DEPTH_WORDS, 256, number of 32-bit storage words; power of two, minimum 4.
REQ-003 Parameter WAIT_CYCLES, 1, extra wait states between accept and response; range 0..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 req_i  input  1  initiator request valid.
REQ-007 we_i  input  1  1 = store, 0 = load.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data.
REQ-010 be_i  input  4  store byte enables; bit n selects wdata_i[8n+7:8n].
REQ-011 gnt_o  output  1  request accepted this cycle when high together with req_i.
REQ-012 rvalid_o  output  1  one-cycle response strobe.
REQ-013 rdata_o  output  32  load data; valid only with rvalid_o.
REQ-014 err_o  output  1  access error; valid only with rvalid_o.

Function
REQ-015 Acceptance occurs in any cycle where req_i and gnt_o are both 1; addr_i, we_i, wdata_i and be_i are captured on that edge.
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 gnt_o is 1 in IDLE and in RESP, and 0 in WAIT.
REQ-018 IDLE: on acceptance, go to WAIT if WAIT_CYCLES > 0, else go to RESP; otherwise stay in IDLE.
REQ-019 WAIT: a 4-bit counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle; at 0, go to RESP.
REQ-020 RESP: rvalid_o is 1 for exactly one cycle.
REQ-021 Leaving RESP: acceptance in the RESP cycle follows the IDLE transition rules (back-to-back); otherwise go to IDLE.
REQ-022 Latency: rvalid_o rises exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-023 Error: err_o is 1 in RESP when the captured address has addr[1:0] != 0, or when (addr - BASE_ADDR) >= DEPTH_WORDS*4 (unsigned 32-bit subtraction, so addresses below BASE_ADDR wrap and also fault).
REQ-024 Word index: (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-025 Load, no error: rdata_o = stored word.
REQ-026 Load with error, and any store: rdata_o = 32'h0.
REQ-027 Store, no error: each byte with be_i=1 is written on the RESP-cycle edge; other bytes keep their value.
REQ-028 Store with error: memory is unchanged.
REQ-029 Store with be_i = 4'b0000: legal; memory unchanged, err_o = 0.
REQ-030 A load accepted in RESP directly after a store to the same word returns the newly written data (read-after-write).
REQ-031 req_i deasserting while gnt_o = 0 has no effect; no request is queued.

Reset
REQ-032 While rst_n = 0 at a clock edge: state = IDLE, counter = 0, rvalid_o = 0, err_o = 0, rdata_o = 32'h0.
REQ-033 Reset during WAIT or RESP abandons the transaction: no response is produced, and any pending store is not written.
REQ-034 Memory contents are not cleared by reset.
REQ-035 gnt_o = 1 in the first cycle after rst_n returns to 1.

Structure
REQ-036 The typedef enum dmem_state_t {DMEM_IDLE, DMEM_WAIT, DMEM_RESP} is added to cpu_pkg.
REQ-037 The constant DMEM_MAX_WAIT = 15 is added to cpu_pkg.
REQ-038 Storage is held in one sub-module, dmem_ram: a synchronous word array with per-byte write enables and a combinational read port.
REQ-039 Parameter values outside their legal range cause an elaboration error.

Verification
REQ-040 WAIT_CYCLES=1: store 32'hDEADBEEF to 32'h10 with be_i=4'hF, then load 32'h10 -> each rvalid_o arrives 2 cycles after its accept; load returns rdata_o=32'hDEADBEEF, err_o=0.
REQ-041 Word at 32'h20 holds 32'h11223344; store 32'hAABBCCDD with be_i=4'b0101, then load 32'h20 -> rdata_o=32'h11BB33DD.
REQ-042 Load from 32'h22 (misaligned) and from 32'h400 (out of range, DEPTH_WORDS=256) -> err_o=1 and rdata_o=0 for both; a store to 32'h400 leaves word 0 unchanged.
REQ-043 WAIT_CYCLES=0, req_i held high for 4 loads -> gnt_o stays 1, rvalid_o is 1 on 4 consecutive cycles, and data is returned in request order.
REQ-044 rst_n pulsed low for 1 cycle during WAIT of a store to 32'h30 with WAIT_CYCLES=3 -> no rvalid_o; a later load of 32'h30 returns the pre-store value.
REQ-045 BASE_ADDR=32'h1000: load 32'h0FFC -> err_o=1 (address below window); load 32'h1000 -> err_o=0, returns word 0.
